// File: rtl/res_axis_streamer_if.sv
// res_axis_streamer_if: AXI-Stream master/slave bundle carrying the result packet
interface res_axis_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tready;
  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/res_axis_streamer.sv
// res_axis_streamer: reads result matrix R from BRAM in row-major order and emits it as one AXI-Stream packet
module res_axis_streamer #(
  parameter int DIM_LOG = 1,
  parameter int DATA_WIDTH = 32,
  localparam int DIM = 2**DIM_LOG,
  localparam int SIZE = DIM*DIM,
  localparam int SIZE_LOG = 2*DIM_LOG
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [SIZE_LOG-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  res_axis_if.master            m00_axis
);
  typedef logic [SIZE_LOG:0] cnt_t;
  localparam cnt_t SIZE_C = cnt_t'(SIZE);
  localparam cnt_t LAST_C = cnt_t'(SIZE-1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  logic [0:0] state_q, state_d;
  cnt_t issued_q, issued_d, sent_q, sent_d;
  logic [1:0] count_q, count_d;
  logic inflight_q, inflight_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic [DATA_WIDTH-1:0] skid_d [2];
  logic stream, valid, pop, more, last, tail;
  assign stream = state_q == STREAM;
  assign valid = count_q != 2'd0;
  assign pop = valid & m00_axis.tready;
  assign more = issued_q < SIZE_C;
  assign last = sent_q == LAST_C;
  // a read is only issued if its word is guaranteed a free slot when it lands
  assign rd_en = stream && more && (count_q + 2'(inflight_q) - 2'(pop)) < 2'd2;
  assign rd_addr = more ? issued_q[SIZE_LOG-1:0] : LAST_C[SIZE_LOG-1:0];
  assign tail = count_q[0] & ~pop;
  assign busy = stream;
  assign done = done_q;
  assign m00_axis.tvalid = valid;
  assign m00_axis.tdata = skid_q[0];
  assign m00_axis.tstrb = '1;
  assign m00_axis.tlast = valid & last;
  always_comb begin
    state_d = state_q;
    issued_d = issued_q + cnt_t'(rd_en);
    sent_d = sent_q + cnt_t'(pop);
    count_d = count_q + 2'(inflight_q) - 2'(pop);
    inflight_d = rd_en;
    done_d = 1'b0;
    skid_d = skid_q;
    if (pop) skid_d[0] = skid_q[1];
    if (inflight_q) skid_d[tail] = rd_data;
    if (!stream && start) begin
      state_d = STREAM;
      issued_d = '0;
      sent_d = '0;
      count_d = '0;
      inflight_d = 1'b0;
    end
    if (pop && last) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= IDLE;
      issued_q <= '0;
      sent_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      sent_q <= sent_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      done_q <= done_d;
      skid_q <= skid_d;
    end
  end
endmodule
